myproject_dense_acc: RTL

- Downstream consumer of the 13s x 6ns -> 18-bit product multiplier in the dense-layer datapath.
- Accumulates N_IN signed products for one output neuron, with the bias folded in on the first beat.
- Then rounds, right-shifts, applies optional ReLU and saturates.
- Emits one result per vector on a valid/ready stream to the next layer.

---
 rtl/myproject_dense_pkg.sv | 26 ++
 rtl/myproject_round_sat.sv | 54 +++++
 rtl/myproject_dense_acc.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/myproject_dense_pkg.sv
// Shared definitions for the dense-layer accumulate stage.
// Contents:
//   PROD_WIDTH / OUT_WIDTH - default widths shared with the multiplier stage
//   state_e                - accumulator FSM states
//   cnt_width()            - width of a counter that must reach n-1
package myproject_dense_pkg;

   localparam int PROD_WIDTH = 18;
   localparam int OUT_WIDTH  = 16;

   typedef enum logic [1:0] {
      ACC  = 2'd0,
      POST = 2'd1,
      OUT  = 2'd2
   } state_e;

   // A counter that runs 0..n-1 needs clog2(n) bits, but never fewer than one.
   function automatic int cnt_width(input int n);
      if (n > 2) begin
         return $clog2(n);
      end else begin
         return 1;
      end
   endfunction

endpackage

// File: rtl/myproject_round_sat.sv
// Purely combinational output conditioning for a dense-layer accumulator.
// It rounds half up, arithmetic-shifts right by SHIFT, optionally clamps
// negatives to zero, and saturates to a signed OUT_WIDTH result.
// Ports:
//   acc_i  in   ACC_WIDTH  signed accumulator value
//   res_o  out  OUT_WIDTH  signed rounded / shifted / clamped result
module myproject_round_sat #(
   parameter int ACC_WIDTH = 24,
   parameter int SHIFT     = 4,
   parameter int OUT_WIDTH = 16,
   parameter int RELU      = 1
) (
   input  logic signed [ACC_WIDTH-1:0] acc_i,
   output logic signed [OUT_WIDTH-1:0] res_o
);

   // One extra bit lets the rounding add happen without wrap; the width is
   // widened further if needed so the saturation limits are representable.
   localparam int SUM_W = ACC_WIDTH + 1;
   localparam int CMP_W = (SUM_W > OUT_WIDTH + 1) ? SUM_W : OUT_WIDTH + 1;

   localparam logic signed [CMP_W-1:0] HALF_K = CMP_W'(64'sd1 <<< (SHIFT - 1));
   localparam logic signed [CMP_W-1:0] MAX_K  = CMP_W'((64'sd1 <<< (OUT_WIDTH - 1)) - 64'sd1);
   localparam logic signed [CMP_W-1:0] MIN_K  = CMP_W'(-(64'sd1 <<< (OUT_WIDTH - 1)));

   logic signed [CMP_W-1:0] ext_s;
   logic signed [CMP_W-1:0] sum_s;
   logic signed [CMP_W-1:0] shr_s;
   logic signed [CMP_W-1:0] relu_s;

   // Round, shift, clamp and saturate the accumulator value.
   always_comb begin
      ext_s  = CMP_W'(acc_i);
      sum_s  = ext_s + HALF_K;
      shr_s  = sum_s >>> SHIFT;
      relu_s = shr_s;
      res_o  = {OUT_WIDTH{1'b0}};

      if ((RELU != 0) && shr_s[CMP_W-1]) begin
         relu_s = {CMP_W{1'b0}};
      end else begin
         relu_s = shr_s;
      end

      if (relu_s > MAX_K) begin
         res_o = MAX_K[OUT_WIDTH-1:0];
      end else if (relu_s < MIN_K) begin
         res_o = MIN_K[OUT_WIDTH-1:0];
      end else begin
         res_o = relu_s[OUT_WIDTH-1:0];
      end
   end

endmodule

// File: rtl/myproject_dense_acc.sv
// Dense-layer output-neuron accumulator.
// It sums N_IN signed products, with the bias folded into the first beat.
// It then rounds, shifts, optionally applies ReLU and saturates, and emits
// one result per vector on a valid/ready stream.
// Ports:
//   ap_clk       in   1           clock, rising edge
//   ap_rst       in   1           synchronous reset, active-high
//   prod_tdata   in   PROD_WIDTH  signed product
//   prod_tvalid  in   1           product valid
//   prod_tready  out  1           block accepts product (ACC state only)
//   bias         in   BIAS_WIDTH  signed bias, sampled on the first beat
//   res_tdata    out  OUT_WIDTH   signed result
//   res_tvalid   out  1           result valid
//   res_tready   in   1           downstream accepts result
//   busy         out  1           vector in progress or result pending
module myproject_dense_acc #(
   parameter int N_IN       = 16,
   parameter int PROD_WIDTH = myproject_dense_pkg::PROD_WIDTH,
   parameter int BIAS_WIDTH = 18,
   parameter int ACC_WIDTH  = 24,
   parameter int SHIFT      = 4,
   parameter int OUT_WIDTH  = myproject_dense_pkg::OUT_WIDTH,
   parameter int RELU       = 1
) (
   input  logic                         ap_clk,
   input  logic                         ap_rst,
   input  logic signed [PROD_WIDTH-1:0] prod_tdata,
   input  logic                         prod_tvalid,
   output logic                         prod_tready,
   input  logic signed [BIAS_WIDTH-1:0] bias,
   output logic signed [OUT_WIDTH-1:0]  res_tdata,
   output logic                         res_tvalid,
   input  logic                         res_tready,
   output logic                         busy
);

   import myproject_dense_pkg::*;

   localparam int                    CNT_WIDTH = cnt_width(N_IN);
   localparam logic [CNT_WIDTH-1:0]  LAST_CNT  = CNT_WIDTH'(N_IN - 1);

   state_e                        state_q, state_d;
   logic [CNT_WIDTH-1:0]          cnt_q, cnt_d;
   logic signed [ACC_WIDTH-1:0]   acc_q, acc_d;
   logic signed [OUT_WIDTH-1:0]   res_q, res_d;
   logic                          vld_q, vld_d;

   logic                          rdy_s;
   logic                          beat_s;
   logic signed [ACC_WIDTH-1:0]   prod_ext_s;
   logic signed [ACC_WIDTH-1:0]   bias_ext_s;
   logic signed [OUT_WIDTH-1:0]   rs_out_s;

   myproject_round_sat #(
      .ACC_WIDTH (ACC_WIDTH),
      .SHIFT     (SHIFT),
      .OUT_WIDTH (OUT_WIDTH),
      .RELU      (RELU)
   ) u_round_sat (
      .acc_i (acc_q),
      .res_o (rs_out_s)
   );

   // Ready depends only on the registered state, so there is no input-to-ready path.
   assign rdy_s       = (state_q == ACC);
   assign beat_s      = prod_tvalid & rdy_s;
   assign prod_ext_s  = ACC_WIDTH'(prod_tdata);
   assign bias_ext_s  = ACC_WIDTH'(bias);

   assign prod_tready = rdy_s;
   assign res_tdata   = res_q;
   assign res_tvalid  = vld_q;
   assign busy        = (cnt_q != {CNT_WIDTH{1'b0}}) || (state_q != ACC);

   // Next-state logic: accumulate beats, condition the sum, then hold until drained.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      res_d   = res_q;
      vld_d   = vld_q;

      case (state_q)
         ACC: begin
            if (beat_s) begin
               // The first beat replaces the stale sum with bias + product.
               if (cnt_q == {CNT_WIDTH{1'b0}}) begin
                  acc_d = bias_ext_s + prod_ext_s;
               end else begin
                  acc_d = acc_q + prod_ext_s;
               end
               if (cnt_q == LAST_CNT) begin
                  cnt_d   = {CNT_WIDTH{1'b0}};
                  state_d = POST;
               end else begin
                  cnt_d   = cnt_q + CNT_WIDTH'(1);
               end
            end else begin
               acc_d = acc_q;
            end
         end
         POST: begin
            res_d   = rs_out_s;
            vld_d   = 1'b1;
            state_d = OUT;
         end
         OUT: begin
            if (res_tready) begin
               vld_d   = 1'b0;
               state_d = ACC;
            end else begin
               vld_d   = 1'b1;
            end
         end
         default: begin
            state_d = ACC;
            cnt_d   = {CNT_WIDTH{1'b0}};
            vld_d   = 1'b0;
         end
      endcase
   end

   // State register with synchronous reset that abandons any partial sum or pending result.
   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         state_q <= ACC;
         cnt_q   <= {CNT_WIDTH{1'b0}};
         acc_q   <= {ACC_WIDTH{1'b0}};
         res_q   <= {OUT_WIDTH{1'b0}};
         vld_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         res_q   <= res_d;
         vld_q   <= vld_d;
      end
   end

endmodule
